// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF and DM; DM has priority,
// IF wins after a capped DM streak, and accesses abort after a response timeout.
module mem_port_arbiter #(
  parameter int MAX_STREAK = 3,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid,
  output logic [31:0] if_rdata,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_valid,
  output logic [31:0] dm_rdata,
  output logic        dm_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err
);
  localparam int SW = $clog2(MAX_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] IDLE = 2'd0, BUSY_IF = 2'd1, BUSY_DM = 2'd2;
  logic [1:0] state;
  logic [SW-1:0] streak;
  logic [TW-1:0] tcnt;
  logic pick_dm, done;
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_valid;
  assign pick_dm = dm_req & (~if_req | (streak != SW'(MAX_STREAK)));
  assign done = mem_ready | (tcnt == TW'(TIMEOUT - 1));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      streak <= '0;
      tcnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
      err <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (state == IDLE) begin
        if (dm_req | if_req) begin
          mem_req <= 1'b1;
          tcnt <= '0;
          if (pick_dm) begin
            state <= BUSY_DM;
            mem_addr <= dm_addr;
            mem_we <= dm_we;
            mem_wdata <= dm_wdata;
            streak <= ~if_req ? '0 : (streak == SW'(MAX_STREAK) ? streak : streak + SW'(1));
          end else begin
            state <= BUSY_IF;
            mem_addr <= if_addr;
            mem_we <= 1'b0;
            streak <= '0;
          end
        end
      end else if (done) begin
        // a ready on the final timeout cycle still counts as a normal completion
        state <= IDLE;
        mem_req <= 1'b0;
        mem_we <= 1'b0;
        err <= err | ~mem_ready;
        if (state == BUSY_IF) begin
          if_valid <= 1'b1;
          if_rdata <= mem_ready ? mem_rdata : '0;
        end else begin
          dm_valid <= 1'b1;
          if (!mem_ready) dm_rdata <= '0;
          else if (!mem_we) dm_rdata <= mem_rdata;
        end
      end else begin
        tcnt <= tcnt + TW'(1);
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with grant and response scoreboards
// checked by independent monitors.
module tb_mem_port_arbiter;
  typedef struct { bit dm; logic [31:0] rdata; bit err; } rsp_t;
  typedef struct { logic [31:0] addr; bit we; logic [31:0] wdata; } gnt_t;
  logic clk = 0, rst;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic if_valid, dm_valid, if_stall, dm_stall, mem_req, mem_we, err, mem_ready;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic resp_ready = 0, stray = 0;
  bit mem_en = 1, prev_req = 0;
  int lat = 0, busy_n = 0, tests = 0, fails = 0;
  rsp_t rsp_q[$];
  gnt_t gnt_q[$];
  assign mem_ready = resp_ready | stray;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst || !mem_req) begin
      busy_n = 0;
      resp_ready = 0;
    end else begin
      resp_ready = mem_en && busy_n == lat;
      busy_n++;
    end
  end

  always @(negedge clk) begin
    if (mem_req && !prev_req) begin
      if (gnt_q.size() == 0) chk("unexpected_grant", mem_addr, 32'hFFFF_FFFF);
      else begin
        automatic gnt_t g = gnt_q.pop_front();
        chk("grant_addr", mem_addr, g.addr);
        chk("grant_we", {31'b0, mem_we}, {31'b0, g.we});
        if (g.we) chk("grant_wdata", mem_wdata, g.wdata);
      end
    end
    prev_req = mem_req;
  end

  always @(negedge clk) begin
    if (if_valid && dm_valid) chk("both_valid", 32'd1, 32'd0);
    else if (if_valid || dm_valid) begin
      if (rsp_q.size() == 0) chk("unexpected_valid", {31'b0, dm_valid}, 32'hFFFF_FFFF);
      else begin
        automatic rsp_t r = rsp_q.pop_front();
        chk("rsp_port_dm", {31'b0, dm_valid}, {31'b0, r.dm});
        chk("rsp_rdata", dm_valid ? dm_rdata : if_rdata, r.rdata);
        chk("rsp_err", {31'b0, err}, {31'b0, r.err});
      end
    end
  end

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(if_valid || dm_valid) && n < budget);
    chk("valid_seen", {31'b0, if_valid | dm_valid}, 32'd1);
  endtask

  task automatic push_gnt(input logic [31:0] a, input bit we, input logic [31:0] wd);
    gnt_t g;
    g.addr = a; g.we = we; g.wdata = wd;
    gnt_q.push_back(g);
  endtask

  task automatic push_rsp(input bit dm, input logic [31:0] rd, input bit e);
    rsp_t r;
    r.dm = dm; r.rdata = rd; r.err = e;
    rsp_q.push_back(r);
  endtask

  initial begin
    int n, hold;
    rst = 0;
    #1 rst = 1;
    #2;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valids", {30'b0, if_valid, dm_valid}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    @(negedge clk);
    @(negedge clk) rst = 0;
    // single read
    push_gnt(32'h40, 0, 0);
    push_rsp(1, 32'h1234, 0);
    mem_rdata = 32'h1234; lat = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    wait_valid(10, n);
    chk("read_latency", n, 2);
    chk("read_dm_stall", {31'b0, dm_stall}, 0);
    dm_req = 0;
    @(negedge clk);
    chk("read_pulse_len", {31'b0, dm_valid}, 0);
    // contention: DM,DM,DM,IF repeated
    mem_rdata = 32'h5555_AAAA;
    if_addr = 32'h200; dm_addr = 32'h300;
    for (int k = 0; k < 8; k++) begin
      push_gnt((k % 4 == 3) ? 32'h200 : 32'h300, 0, 0);
      push_rsp(k % 4 != 3, 32'h5555_AAAA, 0);
    end
    if_req = 1; dm_req = 1;
    for (int k = 0; k < 8; k++) begin
      wait_valid(10, n);
      if (dm_valid) chk("cont_if_stall", {31'b0, if_stall}, 1);
    end
    if_req = 0; dm_req = 0;
    @(negedge clk);
    // write with 3 wait cycles
    push_gnt(32'h80, 1, 32'hCAFE_F00D);
    push_rsp(1, 32'h5555_AAAA, 0);
    lat = 3; mem_rdata = 32'h0BAD_0BAD;
    dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hCAFE_F00D;
    hold = 0; n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mem_req && mem_we && mem_wdata == 32'hCAFE_F00D && mem_addr == 32'h80) hold++;
    end while (!dm_valid && n < 20);
    chk("write_hold", hold, 4);
    chk("write_latency", n, 5);
    dm_req = 0; dm_we = 0;
    @(negedge clk);
    // timeout on IF
    push_gnt(32'h100, 0, 0);
    push_rsp(0, 32'h0, 1);
    mem_en = 0; lat = 0;
    if_req = 1; if_addr = 32'h100;
    wait_valid(40, n);
    chk("timeout_cycles", n, 16);
    chk("timeout_mem_req", {31'b0, mem_req}, 0);
    if_req = 0; mem_en = 1;
    @(negedge clk);
    push_gnt(32'h44, 0, 0);
    push_rsp(1, 32'h77, 1);
    mem_rdata = 32'h77;
    dm_req = 1; dm_addr = 32'h44;
    wait_valid(10, n);
    dm_req = 0;
    @(negedge clk);
    chk("err_sticky", {31'b0, err}, 1);
    // async reset in the middle of a DM wait
    push_gnt(32'h48, 0, 0);
    lat = 100;
    dm_req = 1; dm_addr = 32'h48;
    @(negedge clk);
    @(negedge clk);
    dm_req = 0; if_req = 1; if_addr = 32'h104;
    #2 rst = 1;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 0);
    chk("arst_dm_valid", {31'b0, dm_valid}, 0);
    chk("arst_err", {31'b0, err}, 0);
    @(negedge clk);
    push_gnt(32'h104, 0, 0);
    push_rsp(0, 32'hBEEF, 0);
    lat = 0; mem_rdata = 32'hBEEF;
    rst = 0;
    wait_valid(10, n);
    chk("post_rst_latency", n, 2);
    if_req = 0;
    @(negedge clk);
    // stray ready in IDLE
    stray = 1;
    repeat (3) begin
      @(negedge clk);
      chk("stray_no_req", {31'b0, mem_req}, 0);
    end
    stray = 0;
    repeat (3) @(negedge clk);
    chk("rsp_q_drained", rsp_q.size(), 0);
    chk("gnt_q_drained", gnt_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
